// File: rtl/signed_sort4_ctrl_if.sv
// ---------------------------------------------------------------------------
// signed_sort4_ctrl_if
//   Request/response bundle between a requester and the signed 4-element
//   sorter.
//
//   start  requester -> sorter   request a sort (honoured in IDLE/DONE only)
//   din    requester -> sorter   packed elements, element k at [4k+3:4k]
//   busy   sorter -> requester   high while compares are in progress
//   done   sorter -> requester   one-cycle pulse, new dout/swaps valid
//   dout   sorter -> requester   sorted result, [3:0] largest, [15:12] smallest
//   swaps  sorter -> requester   swaps performed by the last completed sort
// ---------------------------------------------------------------------------
interface signed_sort4_ctrl_if;
    logic        start;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [2:0]  swaps;

    modport master (
        output start,
        output din,
        input  busy,
        input  done,
        input  dout,
        input  swaps
    );

    modport slave (
        input  start,
        input  din,
        output busy,
        output done,
        output dout,
        output swaps
    );
endinterface

// File: rtl/signed_sort4_ctrl.sv
// ---------------------------------------------------------------------------
// signed_sort4_ctrl
//   Sorts four signed 4-bit values into descending order with a fixed
//   six-step bubble-sort schedule, one compare/swap per clock, using a single
//   shared subtract-based signed comparator.
//
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of signed_sort4_ctrl_if (start/din in,
//          busy/done/dout/swaps out); all outputs are registered
// ---------------------------------------------------------------------------
module signed_sort4_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    signed_sort4_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // a < b for two's-complement operands, derived from a + ~b + 1 with an
    // explicit ripple carry so that overflow (carry into bit 3 differing from
    // carry out of bit 3) corrects the sign of the difference.
    function automatic logic signed_lt(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] bn;
        logic [3:0] diff;
        logic [4:0] c;
        bn   = ~b;
        c    = 5'd0;
        diff = 4'd0;
        c[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            diff[k]  = a[k] ^ bn[k] ^ c[k];
            c[k + 1] = (a[k] & bn[k]) | (a[k] & c[k]) | (bn[k] & c[k]);
        end
        return diff[3] ^ (c[3] ^ c[4]);
    endfunction

    state_t             r_state;
    logic signed [3:0]  r_elem [4];
    logic [1:0]         r_idx;
    logic [1:0]         r_pass;
    logic [2:0]         r_cnt;
    logic [15:0]        r_dout;
    logic [2:0]         r_swaps;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic signed [3:0]  w_elem_nxt [4];
    logic [1:0]         w_idx_nxt;
    logic [1:0]         w_pass_nxt;
    logic [2:0]         w_cnt_nxt;
    logic [15:0]        w_dout_nxt;
    logic [2:0]         w_swaps_nxt;

    logic [1:0]         w_idx_p1;
    logic signed [3:0]  w_lo;
    logic signed [3:0]  w_hi;
    logic               w_swap;
    logic               w_pass_end;
    logic               w_last;

    assign w_idx_p1   = r_idx + 2'd1;
    assign w_lo       = r_elem[r_idx];
    assign w_hi       = r_elem[w_idx_p1];
    // Strictly-less only: equal neighbours stay in place.
    assign w_swap     = signed_lt(w_lo, w_hi);
    // Pass p compares pairs 0 .. 2-p, so the pass ends when idx reaches 2-p.
    assign w_pass_end = (r_idx == (2'd2 - r_pass));
    assign w_last     = (r_pass == 2'd2) && (r_idx == 2'd0);

    // Next-state and datapath updates.
    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_idx_nxt   = r_idx;
        w_pass_nxt  = r_pass;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        w_swaps_nxt = r_swaps;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    for (int k = 0; k < 4; k++) begin
                        w_elem_nxt[k] = bus.din[4*k +: 4];
                    end
                    w_idx_nxt   = 2'd0;
                    w_pass_nxt  = 2'd0;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = ST_SORT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_SORT: begin
                if (w_swap) begin
                    w_elem_nxt[r_idx]    = w_hi;
                    w_elem_nxt[w_idx_p1] = w_lo;
                    w_cnt_nxt            = r_cnt + 3'd1;
                end

                if (w_last) begin
                    // Publish the post-swap contents of this final compare.
                    w_dout_nxt  = {w_elem_nxt[3], w_elem_nxt[2],
                                   w_elem_nxt[1], w_elem_nxt[0]};
                    w_swaps_nxt = w_cnt_nxt;
                    w_state_nxt = ST_DONE;
                end else if (w_pass_end) begin
                    w_idx_nxt  = 2'd0;
                    w_pass_nxt = r_pass + 2'd1;
                end else begin
                    w_idx_nxt = w_idx_p1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; busy/done are decoded from the next state
    // so they are registered rather than combinational from r_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            for (int k = 0; k < 4; k++) begin
                r_elem[k] <= 4'sd0;
            end
            r_idx   <= 2'd0;
            r_pass  <= 2'd0;
            r_cnt   <= 3'd0;
            r_dout  <= 16'h0000;
            r_swaps <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            for (int k = 0; k < 4; k++) begin
                r_elem[k] <= w_elem_nxt[k];
            end
            r_idx   <= w_idx_nxt;
            r_pass  <= w_pass_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_swaps <= w_swaps_nxt;
            r_busy  <= (w_state_nxt == ST_SORT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.dout  = r_dout;
    assign bus.swaps = r_swaps;

endmodule

// File: tb/tb_signed_sort4_ctrl.sv
// ---------------------------------------------------------------------------
// tb_signed_sort4_ctrl
//   Scoreboard bench for signed_sort4_ctrl: the driver pushes the reference
//   result for every accepted start; a negedge monitor pops and compares on
//   each done pulse.
// ---------------------------------------------------------------------------
module tb_signed_sort4_ctrl;

    typedef struct {
        logic [15:0] dout;
        logic [2:0]  swaps;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   busy_run;
    exp_t sb[$];

    signed_sort4_ctrl_if bus_if();

    signed_sort4_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: descending order by value; the number of bubble-sort swaps
    // equals the number of strictly-ascending pairs (i<j, e_i < e_j).
    function automatic exp_t model(input logic [15:0] d);
        exp_t r;
        int   e[4];
        int   t;
        int   inv;
        for (int k = 0; k < 4; k++) begin
            t = int'(d[4*k +: 4]);
            e[k] = (t > 7) ? t - 16 : t;
        end
        inv = 0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (e[i] < e[j]) inv++;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (e[j] > e[i]) begin
                    t = e[i]; e[i] = e[j]; e[j] = t;
                end
        for (int k = 0; k < 4; k++) r.dout[4*k +: 4] = e[k][3:0];
        r.swaps = inv[2:0];
        r.cyc   = cyc;
        return r;
    endfunction

    // Monitor: compares every done pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus_if.done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("dout", {16'd0, bus_if.dout}, {16'd0, e.dout});
                    chk("swaps", {29'd0, bus_if.swaps}, {29'd0, e.swaps});
                    chk("latency", cyc - e.cyc, 32'd7);
                    chk("busy_cycles", busy_run, 32'd6);
                    chk("busy_with_done", {31'd0, bus_if.busy}, 32'd0);
                end
            end
            if (bus_if.busy === 1'b1) busy_run++;
            else busy_run = 0;
        end else begin
            busy_run = 0;
        end
    end

    // Called at a negedge while the sorter is idle or done.
    task automatic issue(input logic [15:0] d, input bit hold);
        bus_if.start = 1'b1;
        bus_if.din   = d;
        sb.push_back(model(d));
        @(negedge clk);
        if (!hold) bus_if.start = 1'b0;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (bus_if.busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        int gap;
        total    = 0;
        bad      = 0;
        cyc      = 0;
        busy_run = 0;
        rst_n         = 1'b0;
        bus_if.start  = 1'b1;
        bus_if.din    = 16'h1234;

        // Reset with start held high.
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("rst_done", {31'd0, bus_if.done}, 32'd0);
        chk("rst_dout", {16'd0, bus_if.dout}, 32'd0);
        chk("rst_swaps", {29'd0, bus_if.swaps}, 32'd0);
        rst_n        = 1'b1;
        bus_if.start = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, bus_if.busy}, 32'd0);

        // Directed patterns.
        issue(16'h87F3, 1'b0); wait_not_busy(); @(negedge clk);
        issue(16'h73F8, 1'b0); wait_not_busy(); @(negedge clk);
        issue(16'h7878, 1'b0); wait_not_busy(); @(negedge clk);

        // start during SORT is ignored.
        issue(16'h1234, 1'b0);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.din   = 16'hABCD;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_not_busy(); @(negedge clk);

        // Abort on the 3rd SORT cycle.
        issue(16'h5A3C, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        chk("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("abort_done", {31'd0, bus_if.done}, 32'd0);
        chk("abort_dout", {16'd0, bus_if.dout}, 32'd0);
        chk("abort_swaps", {29'd0, bus_if.swaps}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("abort_no_done", {31'd0, bus_if.done}, 32'd0);

        // Fresh sort after abort.
        issue(16'hC4E2, 1'b0); wait_not_busy(); @(negedge clk);

        // Back-to-back with start held through DONE.
        issue(16'h3A9F, 1'b1);
        n = 0;
        while (bus_if.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("b2b_timeout", 32'd1, 32'd0);
        bus_if.din = 16'h0000;
        sb.push_back(model(16'h0000));
        @(negedge clk);
        bus_if.start = 1'b0;
        chk("b2b_accepted", {31'd0, bus_if.busy}, 32'd1);
        wait_not_busy();

        // Random sorts, including immediate restarts from DONE.
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            issue(16'($urandom), 1'b0);
            wait_not_busy();
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
